// File: rtl/inv_sub_bytes_seq_pkg.sv
// rtl/inv_sub_bytes_seq_pkg.sv - shared types and inverse S-box table for the InvSubBytes stage
package inv_sub_bytes_seq_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// rtl/inv_sub_bytes_seq_sbox.sv - combinational AES inverse S-box lookup
module inv_sbox
  import inv_sub_bytes_seq_pkg::*;
(
  input  logic [7:0] lhs,
  output logic [7:0] o
);

  assign o = INV_SBOX[lhs];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential AES InvSubBytes, BYTES_PER_CYCLE bytes per clock
module inv_sub_bytes_seq
  import inv_sub_bytes_seq_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  out_state
);

  localparam int B  = BYTES_PER_CYCLE;
  localparam int N  = 16 / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  fsm_e          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  res_q, res_d;
  logic [3:0]    base;
  logic [7:0]    sb_in  [B];
  logic [7:0]    sb_out [B];

  // Row-major flattening of [row][col] puts byte k = 4r+c at bits [8k +: 8].
  assign base = 4'(int'(cnt_q) * B);

  for (genvar j = 0; j < B; j++) begin : g_sbox
    assign sb_in[j] = work_q[{base + 4'(j), 3'b000} +: 8];
    inv_sbox u_inv_sbox (
      .lhs (sb_in[j]),
      .o   (sb_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < B; j++) begin
          res_d[{base + 4'(j), 3'b000} +: 8] = sb_out[j];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_state = res_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - self-checking bench: GF(2^8)-derived reference model, three widths
module tb_inv_sub_bytes_seq;

  typedef logic [3:0][3:0][7:0] state_t;

  logic   clk;
  logic   rst       [3];
  logic   in_valid  [3];
  logic   in_ready  [3];
  state_t in_state  [3];
  logic   out_valid [3];
  logic   out_ready [3];
  state_t out_state [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sbox_tab [256];
  logic [7:0] inv_tab  [256];

  int     mst   [3];
  int     mleft [3];
  state_t mres  [3];
  state_t mpend [3];
  bit     known [3];

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic state_t inv_state(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = inv_tab[s[r][c]];
    return o;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int k = 0; k < 4; k++) s[k] = $urandom;
    return s;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Abstract transaction model: idle / busy for N edges / holding a result.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (known[d]) begin
        chk(in_ready[d] === (mst[d] == 0), $sformatf("in_ready[%0d]", d), 128'(in_ready[d]), 128'(mst[d] == 0));
        chk(out_valid[d] === (mst[d] == 2), $sformatf("out_valid[%0d]", d), 128'(out_valid[d]), 128'(mst[d] == 2));
        if (mst[d] != 1)
          chk(out_state[d] === mres[d], $sformatf("out_state[%0d]", d), out_state[d], mres[d]);
      end
      if (rst[d]) begin
        mst[d] = 0; mres[d] = '0; known[d] = 1'b1;
      end else if (known[d]) begin
        case (mst[d])
          0: if (in_valid[d]) begin
               mst[d] = 1; mleft[d] = n_of(d); mpend[d] = inv_state(in_state[d]);
             end
          1: begin
               mleft[d]--;
               if (mleft[d] == 0) begin mst[d] = 2; mres[d] = mpend[d]; end
             end
          default: if (out_ready[d]) mst[d] = 0;
        endcase
      end
    end
  end

  task automatic wait_out(input int d, input bit rnd, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      if (rnd) begin
        in_valid[d]  = 1'($urandom_range(0, 1));
        out_ready[d] = 1'($urandom_range(0, 1));
        in_state[d]  = rand_state();
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  task automatic run_block(input int d, input state_t st, input state_t exp, input int bp,
                           input bit rnd, input string tag);
    int t, lat;
    t = 0;
    while (!in_ready[d] && t < 100) begin @(posedge clk); #1; t++; end
    chk(in_ready[d] === 1'b1, {tag, " ready_timeout"}, 128'(in_ready[d]), 128'(1));
    in_valid[d] = 1'b1;
    in_state[d] = st;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_state[d] = rand_state();
    wait_out(d, rnd, lat);
    chk(lat == n_of(d), {tag, " latency"}, 128'(lat), 128'(n_of(d)));
    chk(out_state[d] === exp, {tag, " result"}, out_state[d], exp);
    repeat (bp) begin
      if (rnd) in_valid[d] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk(out_valid[d] === 1'b0, {tag, " handshake_drop"}, 128'(out_valid[d]), 128'(0));
  endtask

  initial begin
    state_t st, exp, st2, hold;
    int lat;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_state[d] = '0;
      mst[d] = 0; mleft[d] = 0; mres[d] = '0; mpend[d] = '0; known[d] = 1'b0;
    end

    // Forward S-box from multiplicative inverse plus affine map; inverse table by inversion.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, s;
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      sbox_tab[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_tab[sbox_tab[x]] = 8'(x);

    chk(sbox_tab[0] === 8'h63, "pin sbox[00]", 128'(sbox_tab[0]), 128'h63);
    chk(sbox_tab[1] === 8'h7c, "pin sbox[01]", 128'(sbox_tab[1]), 128'h7c);
    chk(sbox_tab[3] === 8'h7b, "pin sbox[03]", 128'(sbox_tab[3]), 128'h7b);
    chk(inv_tab[8'h00] === 8'h52, "pin inv[00]", 128'(inv_tab[8'h00]), 128'h52);
    chk(inv_tab[8'hff] === 8'h7d, "pin inv[ff]", 128'(inv_tab[8'hff]), 128'h7d);
    chk(inv_tab[8'hed] === 8'h53, "pin inv[ed]", 128'(inv_tab[8'hed]), 128'h53);
    chk(inv_tab[8'h7c] === 8'h01, "pin inv[7c]", 128'(inv_tab[8'h7c]), 128'h01);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    chk(in_ready[0] === 1'b1, "reset in_ready", 128'(in_ready[0]), 128'(1));
    chk(out_valid[0] === 1'b0, "reset out_valid", 128'(out_valid[0]), 128'(0));
    chk(out_state[0] === '0, "reset out_state", out_state[0], 128'(0));

    for (int k = 0; k < 16; k++) st[k / 4][k % 4] = 8'h63;
    run_block(0, st, '0, 0, 1'b0, "all63");

    for (int k = 0; k < 16; k++) begin
      st[k / 4][k % 4]  = sbox_tab[k];
      exp[k / 4][k % 4] = 8'(k);
    end
    run_block(0, st, exp, 2, 1'b0, "sbox_ramp");

    for (int k = 0; k < 16; k++) begin st[k / 4][k % 4] = 8'h63; exp[k / 4][k % 4] = 8'h00; end
    st[0][0] = 8'h00; exp[0][0] = 8'h52;
    st[0][3] = 8'hff; exp[0][3] = 8'h7d;
    st[3][0] = 8'hed; exp[3][0] = 8'h53;
    st[3][3] = 8'h7c; exp[3][3] = 8'h01;
    run_block(0, st, exp, 1, 1'b0, "corners");

    // Backpressure: result held for 10 cycles while a competing block is offered.
    st = rand_state(); st2 = rand_state();
    in_valid[0] = 1'b1; in_state[0] = st;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_out(0, 1'b0, lat);
    chk(lat == 4, "bp latency", 128'(lat), 128'(4));
    hold = out_state[0];
    chk(hold === inv_state(st), "bp result", hold, inv_state(st));
    in_valid[0] = 1'b1; in_state[0] = st2;
    repeat (10) begin
      @(posedge clk); #1;
      chk(out_valid[0] === 1'b1, "bp out_valid", 128'(out_valid[0]), 128'(1));
      chk(in_ready[0] === 1'b0, "bp in_ready", 128'(in_ready[0]), 128'(0));
      chk(out_state[0] === hold, "bp stable", out_state[0], hold);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk(in_ready[0] === 1'b1, "bp no_same_edge_accept", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_out(0, 1'b0, lat);
    chk(lat == 4, "bp next latency", 128'(lat), 128'(4));
    chk(out_state[0] === inv_state(st2), "bp next result", out_state[0], inv_state(st2));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      st = rand_state();
      for (int k = 0; k < 16; k++) exp[k / 4][k % 4] = sbox_tab[st[k / 4][k % 4]];
      run_block(0, exp, st, $urandom_range(0, 3), 1'b1, "roundtrip4");
    end

    // Reset during the second RUN cycle discards the block.
    in_valid[0] = 1'b1; in_state[0] = rand_state();
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk(in_ready[0] === 1'b1, "midrun_rst in_ready", 128'(in_ready[0]), 128'(1));
    chk(out_valid[0] === 1'b0, "midrun_rst out_valid", 128'(out_valid[0]), 128'(0));
    chk(out_state[0] === '0, "midrun_rst out_state", out_state[0], 128'(0));

    for (int k = 0; k < 16; k++) st[k / 4][k % 4] = 8'h63;
    run_block(1, st, '0, 0, 1'b0, "all63_b1");
    run_block(2, st, '0, 0, 1'b0, "all63_b16");
    for (int i = 0; i < 30; i++) begin
      st = rand_state();
      for (int k = 0; k < 16; k++) exp[k / 4][k % 4] = sbox_tab[st[k / 4][k % 4]];
      run_block(1, exp, st, $urandom_range(0, 2), 1'b1, "roundtrip1");
      run_block(2, exp, st, $urandom_range(0, 2), 1'b1, "roundtrip16");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
